// File: rtl/phase_accu_multi.sv
// Multi-channel phase accumulator with strobed FCW writes, per-channel sync and wrap pulses.
// Optional per-channel address phase offset input enabled by defining PHASE_ACCU_PM_EN.
module phase_accu_multi #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned ACC_W    = 32,
  parameter int unsigned FCW_W    = 24,
  parameter int unsigned ADDR_W   = 16,
  localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                       i_clk5MHz,
  input  logic                       i_rst,
  input  logic                       i_en,
  input  logic                       i_fcw_wr,
  input  logic [CH_W-1:0]            i_fcw_ch,
  input  logic [FCW_W-1:0]           i_fcw,
  input  logic [CHANNELS-1:0]        i_sync,
`ifdef PHASE_ACCU_PM_EN
  input  logic [CHANNELS*ADDR_W-1:0] i_pm,
`endif
  output logic [CHANNELS*ADDR_W-1:0] o_addr,
  output logic [CHANNELS-1:0]        o_wrap
);

  logic [FCW_W-1:0]           fcw_q [CHANNELS];
  logic [FCW_W-1:0]           fcw_d [CHANNELS];
  logic [ACC_W-1:0]           acc_q [CHANNELS];
  logic [ACC_W-1:0]           acc_d [CHANNELS];
  logic [ACC_W:0]             sum   [CHANNELS];
  logic [CHANNELS*ADDR_W-1:0] addr_q, addr_d;
  logic [CHANNELS-1:0]        wrap_q, wrap_d;

  always_comb begin
    addr_d = '0;
    wrap_d = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      fcw_d[c] = fcw_q[c];
      // Out-of-range channel selects never match any c, so they are dropped.
      if (i_fcw_wr && (i_fcw_ch == CH_W'(c))) begin
        fcw_d[c] = i_fcw;
      end

      sum[c]   = {1'b0, acc_q[c]} + {{(ACC_W + 1 - FCW_W){1'b0}}, fcw_q[c]};
      acc_d[c] = acc_q[c];
      if (i_sync[c]) begin
        acc_d[c] = '0;
      end else if (i_en) begin
        acc_d[c]  = sum[c][ACC_W-1:0];
        wrap_d[c] = sum[c][ACC_W];
      end

`ifdef PHASE_ACCU_PM_EN
      addr_d[c*ADDR_W +: ADDR_W] = acc_q[c][ACC_W-1 -: ADDR_W] + i_pm[c*ADDR_W +: ADDR_W];
`else
      addr_d[c*ADDR_W +: ADDR_W] = acc_q[c][ACC_W-1 -: ADDR_W];
`endif
    end
  end

  always_ff @(posedge i_clk5MHz) begin
    if (i_rst) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        fcw_q[c] <= FCW_W'(1);
        acc_q[c] <= '0;
      end
      addr_q <= '0;
      wrap_q <= '0;
    end else begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        fcw_q[c] <= fcw_d[c];
        acc_q[c] <= acc_d[c];
      end
      addr_q <= addr_d;
      wrap_q <= wrap_d;
    end
  end

  assign o_addr = addr_q;
  assign o_wrap = wrap_q;

endmodule

// File: tb/tb_phase_accu_multi.sv
// Self-checking bench for phase_accu_multi: directed scenarios plus randomized traffic
// compared every cycle against an arithmetic reference model.
module tb_phase_accu_multi;

  localparam int unsigned CH     = 3;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned FCW_W  = 24;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned CH_W   = 2;

  logic                 clk = 1'b0;
  logic                 rst, en, fcw_wr;
  logic [CH_W-1:0]      fcw_ch;
  logic [FCW_W-1:0]     fcw;
  logic [CH-1:0]        sync;
  logic [CH*ADDR_W-1:0] addr;
  logic [CH-1:0]        wrap;
`ifdef PHASE_ACCU_PM_EN
  logic [CH*ADDR_W-1:0] pm;
`endif

  always #5 clk = ~clk;

  phase_accu_multi #(
    .CHANNELS (CH),
    .ACC_W    (ACC_W),
    .FCW_W    (FCW_W),
    .ADDR_W   (ADDR_W)
  ) dut (
    .i_clk5MHz (clk),
    .i_rst     (rst),
    .i_en      (en),
    .i_fcw_wr  (fcw_wr),
    .i_fcw_ch  (fcw_ch),
    .i_fcw     (fcw),
    .i_sync    (sync),
`ifdef PHASE_ACCU_PM_EN
    .i_pm      (pm),
`endif
    .o_addr    (addr),
    .o_wrap    (wrap)
  );

  // Reference state kept as plain integers.
  longint unsigned acc_m  [CH];
  longint unsigned fcw_m  [CH];
  longint unsigned addr_m [CH];
  logic [CH-1:0]   wrap_m;
  int              tests = 0;
  int              fails = 0;
  int              wrap_cnt2 = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        acc_m[c]  = 0;
        fcw_m[c]  = 1;
        addr_m[c] = 0;
        wrap_m[c] = 1'b0;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        longint unsigned s;
        longint unsigned pmv;
        pmv = 0;
`ifdef PHASE_ACCU_PM_EN
        pmv = longint'(pm[c*ADDR_W +: ADDR_W]);
`endif
        addr_m[c] = ((acc_m[c] / (64'd1 << (ACC_W - ADDR_W))) + pmv) % (64'd1 << ADDR_W);
        s = acc_m[c] + fcw_m[c];
        if (sync[c]) begin
          acc_m[c]  = 0;
          wrap_m[c] = 1'b0;
        end else if (en) begin
          acc_m[c]  = s % (64'd1 << ACC_W);
          wrap_m[c] = (s >= (64'd1 << ACC_W));
        end else begin
          wrap_m[c] = 1'b0;
        end
      end
      if (fcw_wr && (int'(fcw_ch) < CH)) fcw_m[fcw_ch] = longint'(fcw);
    end
  endtask

  task automatic step();
    logic [CH*ADDR_W-1:0] ea;
    @(posedge clk);
    model_edge();
    #1;
    for (int c = 0; c < CH; c++) ea[c*ADDR_W +: ADDR_W] = ADDR_W'(addr_m[c]);
    check("addr", 64'(addr), 64'(ea));
    check("wrap", 64'(wrap), 64'(wrap_m));
    if (wrap[2] === 1'b1) wrap_cnt2++;
  endtask

  task automatic idle();
    rst    = 1'b0;
    en     = 1'b0;
    fcw_wr = 1'b0;
    fcw_ch = '0;
    fcw    = '0;
    sync   = '0;
`ifdef PHASE_ACCU_PM_EN
    pm     = '0;
`endif
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step();
    check("reset_addr", 64'(addr), 64'd0);
    check("reset_wrap", 64'(wrap), 64'd0);

    // Default FCW of 1: 65536 enabled edges move the address by exactly one.
    rst = 1'b0;
    en  = 1'b1;
    repeat (65536) step();
    en = 1'b0;
    step();
    check("run64k_addr0", 64'(addr[15:0]), 64'h0001);
    check("run64k_addr2", 64'(addr[47:32]), 64'h0001);

    // Ch2 at half-scale/256 wraps every 512 enabled cycles.
    rst = 1'b1;
    step();
    rst    = 1'b0;
    fcw_wr = 1'b1;
    fcw_ch = 2'd2;
    fcw    = 24'h800000;
    step();
    fcw_wr    = 1'b0;
    en        = 1'b1;
    wrap_cnt2 = 0;
    repeat (1024) step();
    check("ch2_wrap_count", 64'(wrap_cnt2), 64'd2);

    // Hard sync on ch1 mid-run.
    fcw_wr = 1'b1;
    fcw_ch = 2'd1;
    fcw    = 24'h100000;
    step();
    fcw_wr = 1'b0;
    repeat (10) step();
    sync = 3'b010;
    step();
    sync = '0;
    step();
    check("sync_addr1", 64'(addr[31:16]), 64'h0000);

    // Enable toggling 1,0,0,1 with FCW 0x010000 on ch0.
    en  = 1'b0;
    rst = 1'b1;
    step();
    rst    = 1'b0;
    fcw_wr = 1'b1;
    fcw_ch = 2'd0;
    fcw    = 24'h010000;
    step();
    fcw_wr = 1'b0;
    en = 1'b1; step();
    en = 1'b0; step();
    step();
    en = 1'b1; step();
    en = 1'b0; step();
    check("toggle_addr0", 64'(addr[15:0]), 64'h0002);

    // Write to a nonexistent channel, then reset mid-run.
    fcw_wr = 1'b1;
    fcw_ch = 2'd3;
    fcw    = 24'hFFFFFF;
    en     = 1'b1;
    step();
    fcw_wr = 1'b0;
    repeat (20) step();
    rst = 1'b1;
    step();
    check("midrst_addr", 64'(addr), 64'd0);
    rst = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      en     = ($urandom_range(0, 3) != 0);
      fcw_wr = ($urandom_range(0, 7) == 0);
      fcw_ch = CH_W'($urandom_range(0, 3));
      fcw    = $urandom_range(0, 1) ? FCW_W'($urandom) : FCW_W'($urandom_range(0, 255) << 16);
      for (int c = 0; c < CH; c++) sync[c] = ($urandom_range(0, 31) == 0);
      rst    = ($urandom_range(0, 199) == 0);
`ifdef PHASE_ACCU_PM_EN
      pm     = CH*ADDR_W'({$urandom, $urandom});
`endif
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/phase_accu_multi.md
# phase_accu_multi

Parametrised multi-channel phase accumulator, successor to the single-channel 5 MHz ramp generator that drives the wavetable address path. Each of `CHANNELS` independent accumulators adds its own frequency control word (FCW) every enabled clock, modulo 2^`ACC_W`. The block presents the top `ADDR_W` bits of each accumulator as a registered table address and flags each wrap-around with a one-cycle pulse. Per-channel hard sync and strobed FCW writes replace the old level-sensitive FCW capture.

## Interface
- `CHANNELS`, 4, number of independent accumulators (>=1)
- `ACC_W`, 32, accumulator width in bits
- `FCW_W`, 24, FCW width in bits (<= `ACC_W`)
- `ADDR_W`, 16, output address width per channel (<= `ACC_W`)
- `CH_W`, `$clog2(CHANNELS)` (min 1), channel-select width (derived, not overridden)

Ports:
- `i_clk5MHz` input 1, sole clock; all state changes on its rising edge
- `i_rst` input 1, synchronous, active-high reset
- `i_en` input 1, accumulate enable (sample tick)
- `i_fcw_wr` input 1, FCW write strobe
- `i_fcw_ch` input `CH_W`, channel selected by `i_fcw_wr`
- `i_fcw` input `FCW_W`, FCW value written on strobe
- `i_sync` input `CHANNELS`, per-channel hard sync (bit c -> channel c)
- `i_pm` input `CHANNELS*ADDR_W`, per-channel phase offset; present only with `PHASE_ACCU_PM_EN`
- `o_addr` output `CHANNELS*ADDR_W`, channel c at bits `[c*ADDR_W +: ADDR_W]`, registered
- `o_wrap` output `CHANNELS`, one-cycle pulse per channel on accumulator carry-out

## Operation
- Per channel c: `fcw[c]` (`FCW_W` bits) and `acc[c]` (`ACC_W` bits).
- Reset (`i_rst`=1 at an edge): `fcw[c]`=1, `acc[c]`=0, `o_addr`=0, `o_wrap`=0. Overrides all other inputs, including mid-run.
- FCW write: when `i_fcw_wr`=1, `fcw[i_fcw_ch]` <= `i_fcw`. When `i_fcw_ch` >= `CHANNELS`, the write is ignored with no side effects.
- Accumulate: when `i_en`=1, `acc[c]` <= (`acc[c]` + zero-extended `fcw[c]`) mod 2^`ACC_W`, and `o_wrap[c]` <= carry-out of that sum.
- When `i_en`=0, `acc` holds and `o_wrap` <= 0.
- Sync: when `i_sync[c]`=1, `acc[c]` <= 0 and `o_wrap[c]` <= 0. Sync takes priority over `i_en` for that channel only.
- Simultaneous events:
  - Write plus accumulate on the same channel: the accumulate uses the old `fcw` and the new value applies from the next edge.
  - Write plus sync: both take effect.
  - Wrap plus sync: sync wins, so no pulse.
- Address: `o_addr[c]` <= `acc[c][ACC_W-1 -: ADDR_W]`, with an optional offset (see Configuration). The address is registered every cycle regardless of `i_en`.

## Timing
- FCW write latency: the written value first affects `acc` at edge N+1 after the write edge N.
- `acc` updates at edge N; `o_addr` reflects it at edge N+1, giving 1 cycle of address latency.
- `o_wrap[c]` asserts in the same cycle that the wrapped `acc[c]` value is present. It therefore leads the corresponding `o_addr` update by 1 cycle.
- Wrap period for constant `fcw` = F with `i_en` held at 1: 2^`ACC_W`/F enabled cycles, exact when F divides 2^`ACC_W`.
- Setting `fcw` = 0 freezes the channel; `o_wrap` never asserts.
- Sync-to-address latency is 2 edges: `acc`=0 after edge N, `o_addr`=0 (or `i_pm`) after edge N+1.

## Configuration
- `PHASE_ACCU_PM_EN` defined:
  - `i_pm` port exists.
  - `o_addr[c]` <= (`acc[c]` top bits + `i_pm[c]`) mod 2^`ADDR_W`, with `i_pm` sampled on the same edge, so latency is unchanged.
  - `o_wrap` ignores `i_pm`.
- `PHASE_ACCU_PM_EN` undefined:
  - No `i_pm` port.
  - `o_addr[c]` is the accumulator top bits only.

## Test plan
- Defaults, reset, then `i_en`=1 for 65536 cycles with no writes: `acc[0]`=0x00010000 and `o_addr` ch0 = 0x0001 one cycle later. All channels are identical and `o_wrap` stays 0.
- Write ch2 `i_fcw`=0x800000, `i_en`=1: ch2 `o_addr` steps 0x0000, 0x0080, 0x0100, … `o_wrap[2]` pulses once every 512 enabled cycles, and other channels are unaffected.
- Load ch1 with FCW 0x100000, run 10 cycles, assert `i_sync[1]` together with `i_en`=1: `acc[1]`=0 after that edge and `o_addr` ch1 = 0x0000 one edge later. Ch1 resumes counting from 0.
- Toggle `i_en` 1,0,0,1 with FCW 0x010000: `o_addr` ch0 increments by 0x0001 only on enabled edges, holds otherwise, and `o_wrap`=0 while disabled.
- `CHANNELS`=3, write `i_fcw_ch`=3 with 0xFFFFFF: no channel changes. Then assert `i_rst` mid-run: all `o_addr`=0, `o_wrap`=0, and every `fcw` is back to 1.
- With `PHASE_ACCU_PM_EN`, ch0 top bits = 0x0001 and `i_pm` ch0 = 0xFFFF: `o_addr` ch0 = 0x0000 (modular add). `o_wrap[0]` is unaffected.
